// File: rtl/darkmem_arb_pkg.sv
// Shared types and helpers for the darkmem_arb program/data RAM arbiter.
// Optional build macro: DARKMEM_ARB_ROUND_ROBIN_EN (affects darkmem_arb_pick only).
package darkmem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {GNT_INSTR, GNT_DATA} grant_t;

  localparam logic [3:0] BE_FULL = 4'hF;

  // A zero byte-enable mask from the data port means a full-word access.
  function automatic logic [3:0] norm_be(input logic [3:0] be);
    return (be == 4'h0) ? BE_FULL : be;
  endfunction

endpackage

// File: rtl/darkmem_arb_pick.sv
// Grant selection between the fetch and data requesters.
// DARKMEM_ARB_ROUND_ROBIN_EN: alternate on collisions; otherwise data port always wins.
module darkmem_arb_pick
  import darkmem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  grant_t last_grant,
  output grant_t grant
);

`ifdef DARKMEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = GNT_INSTR;
    if (i_req && d_req) begin
      grant = (last_grant == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
    end else if (d_req) begin
      grant = GNT_DATA;
    end
  end
`else
  // Fixed priority ignores history and the fetch request level.
  logic unused_pick;
  assign unused_pick = ^{i_req, last_grant};

  always_comb begin
    grant = d_req ? GNT_DATA : GNT_INSTR;
  end
`endif

endmodule

// File: rtl/darkmem_arb.sv
// Fetch/data arbiter and access sequencer for a single-port RAM with ACK timeout.
// Build macro DARKMEM_ARB_ROUND_ROBIN_EN selects round-robin collision handling.
module darkmem_arb
  import darkmem_arb_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int AW       = 32
) (
  input  logic          XCLK,
  input  logic          XRES,
  input  logic          I_RD,
  input  logic [AW-1:0] I_ADDR,
  output logic [31:0]   I_DATA,
  output logic          I_ACK,
  input  logic          D_RD,
  input  logic          D_WR,
  input  logic [3:0]    D_BE,
  input  logic [AW-1:0] D_ADDR,
  input  logic [31:0]   D_WDATA,
  output logic [31:0]   D_RDATA,
  output logic          D_ACK,
  output logic          ERR,
  output logic          M_EN,
  output logic          M_RD,
  output logic          M_WR,
  output logic [3:0]    M_BE,
  output logic [AW-1:0] M_ADDR,
  output logic [31:0]   M_WDATA,
  input  logic [31:0]   M_RDATA,
  input  logic          M_ACK
);

  localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

  state_t        state_reg, state_next;
  grant_t        grant_reg, grant_next;
  grant_t        last_grant_reg, last_grant_next;
  grant_t        pick_grant;
  logic [7:0]    cnt_reg, cnt_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [3:0]    be_reg, be_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic [31:0]   rdata_reg, rdata_next;
  logic          wr_reg, wr_next;
  logic          err_reg, err_next;
  logic          i_req, d_req, access;

  assign i_req = I_RD;
  assign d_req = D_RD | D_WR;

  darkmem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant_reg),
    .grant      (pick_grant)
  );

  always_ff @(posedge XCLK or negedge XRES) begin
    if (!XRES) begin
      state_reg      <= IDLE;
      grant_reg      <= GNT_INSTR;
      last_grant_reg <= GNT_INSTR;
      cnt_reg        <= 8'd0;
      addr_reg       <= '0;
      be_reg         <= 4'h0;
      wdata_reg      <= 32'h0;
      rdata_reg      <= 32'h0;
      wr_reg         <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      addr_reg       <= addr_next;
      be_reg         <= be_next;
      wdata_reg      <= wdata_next;
      rdata_reg      <= rdata_next;
      wr_reg         <= wr_next;
      err_reg        <= err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    addr_next       = addr_reg;
    be_next         = be_reg;
    wdata_next      = wdata_reg;
    rdata_next      = rdata_reg;
    wr_next         = wr_reg;
    err_next        = err_reg;
    case (state_reg)
      IDLE: begin
        if (i_req || d_req) begin
          grant_next = pick_grant;
          cnt_next   = 8'd0;
          state_next = ACCESS;
          if (pick_grant == GNT_DATA) begin
            addr_next  = D_ADDR;
            be_next    = norm_be(D_BE);
            wdata_next = D_WDATA;
            wr_next    = D_WR;
          end else begin
            addr_next  = I_ADDR;
            be_next    = BE_FULL;
            wdata_next = 32'h0;
            wr_next    = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (M_ACK) begin
          rdata_next = wr_reg ? 32'h0 : M_RDATA;
          err_next   = 1'b0;
          state_next = RESP;
        end else if (cnt_reg == CNT_LAST) begin
          rdata_next = 32'h0;
          err_next   = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      RESP: begin
        last_grant_next = grant_reg;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory strobes come only from the latched request, and only while in ACCESS.
  assign access  = (state_reg == ACCESS);
  assign M_EN    = access;
  assign M_WR    = access & wr_reg;
  assign M_RD    = access & ~wr_reg;
  assign M_BE    = access ? be_reg : 4'h0;
  assign M_ADDR  = access ? addr_reg : '0;
  assign M_WDATA = access ? wdata_reg : 32'h0;

  assign I_ACK   = (state_reg == RESP) && (grant_reg == GNT_INSTR);
  assign D_ACK   = (state_reg == RESP) && (grant_reg == GNT_DATA);
  assign I_DATA  = rdata_reg;
  assign D_RDATA = rdata_reg;
  assign ERR     = err_reg;

endmodule

// File: tb/tb_darkmem_arb.sv
// Self-checking bench for darkmem_arb: directed steps plus random transactions
// against a transaction-level model with its own copy of memory contents.
module tb_darkmem_arb;

  localparam int WAIT_MAX = 15;
  localparam int AW       = 32;

  logic          XCLK = 1'b0;
  logic          XRES = 1'b0;
  logic          I_RD;
  logic [AW-1:0] I_ADDR;
  logic [31:0]   I_DATA;
  logic          I_ACK;
  logic          D_RD;
  logic          D_WR;
  logic [3:0]    D_BE;
  logic [AW-1:0] D_ADDR;
  logic [31:0]   D_WDATA;
  logic [31:0]   D_RDATA;
  logic          D_ACK;
  logic          ERR;
  logic          M_EN;
  logic          M_RD;
  logic          M_WR;
  logic [3:0]    M_BE;
  logic [AW-1:0] M_ADDR;
  logic [31:0]   M_WDATA;
  logic [31:0]   M_RDATA;
  logic          M_ACK;

  darkmem_arb #(.WAIT_MAX(WAIT_MAX), .AW(AW)) dut (
    .XCLK(XCLK), .XRES(XRES),
    .I_RD(I_RD), .I_ADDR(I_ADDR), .I_DATA(I_DATA), .I_ACK(I_ACK),
    .D_RD(D_RD), .D_WR(D_WR), .D_BE(D_BE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
    .D_RDATA(D_RDATA), .D_ACK(D_ACK), .ERR(ERR),
    .M_EN(M_EN), .M_RD(M_RD), .M_WR(M_WR), .M_BE(M_BE), .M_ADDR(M_ADDR),
    .M_WDATA(M_WDATA), .M_RDATA(M_RDATA), .M_ACK(M_ACK)
  );

  always #5 XCLK = ~XCLK;

  int total = 0;
  int bad   = 0;
  int exp_last = 0;            // 0 = fetch port served last, 1 = data port
  logic [31:0] ram     [16];   // memory device contents (written through M_*)
  logic [31:0] ref_mem [16];   // model's expected contents

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] be_norm(input logic [3:0] be);
    return (be == 4'h0) ? 4'hF : be;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Starts at a falling edge with the arbiter idle; ends one idle cycle after the last ACK.
  // force_d >= 0 fixes the memory ACK delay, otherwise it is randomized per access.
  task automatic run_txn(input bit ireq, input bit dreq, input bit dwr, input logic [3:0] be,
                         input logic [31:0] iaddr, input logic [31:0] daddr,
                         input logic [31:0] wd, input int force_d);
    int order[$];
    int cyc, base, acc_k, cur_d, p, len_exp;
    bit err_exp, wr_exp;
    logic [31:0] a, data_exp;
    logic [3:0] idx;
    if (ireq && dreq) begin
`ifdef DARKMEM_ARB_ROUND_ROBIN_EN
      if (exp_last == 1) begin order.push_back(0); order.push_back(1); end
      else begin order.push_back(1); order.push_back(0); end
`else
      order.push_back(1); order.push_back(0);
`endif
    end else if (dreq) order.push_back(1);
    else order.push_back(0);
    I_RD = ireq; I_ADDR = iaddr;
    D_WR = dreq & dwr;
    D_RD = dreq & (~dwr | ($urandom_range(0, 1) == 1));
    D_BE = be; D_ADDR = daddr; D_WDATA = wd;
    cyc = 0; base = 0; acc_k = 0; cur_d = 0;
    while (order.size() > 0 && cyc < 100) begin
      @(posedge XCLK); cyc++;
      @(negedge XCLK);
      chk("single_ack", 64'(I_ACK & D_ACK), 64'(0));
      if (I_ACK || D_ACK) begin
        p = order.pop_front();
        a = p ? daddr : iaddr;
        idx = a[5:2];
        len_exp = (cur_d < WAIT_MAX) ? cur_d + 1 : WAIT_MAX;
        err_exp = (cur_d >= WAIT_MAX);
        data_exp = (err_exp || (p == 1 && dwr)) ? 32'h0 : ref_mem[idx];
        chk("ack_port", 64'({I_ACK, D_ACK}), p ? 64'(2'b01) : 64'(2'b10));
        chk("ack_cycle", 64'(cyc), 64'(base + 1 + len_exp));
        chk("men_in_resp", 64'(M_EN), 64'(0));
        chk("err", 64'(ERR), 64'(err_exp));
        if (p == 1) chk("d_rdata", 64'(D_RDATA), 64'(data_exp));
        else        chk("i_data", 64'(I_DATA), 64'(data_exp));
        if (p == 1 && dwr && !err_exp) ref_mem[idx] = merge(ref_mem[idx], wd, be_norm(be));
        $display("txn port=%s op=%s addr=%h be=%h err=%0d data=%h ack_cyc=%0d",
                 p ? "D" : "I", (p == 1 && dwr) ? "WR" : "RD", a,
                 p ? be_norm(be) : 4'hF, err_exp, p ? D_RDATA : I_DATA, cyc);
        exp_last = p;
        base = cyc + 1;
        acc_k = 0;
        if (p == 1) begin D_RD = 1'b0; D_WR = 1'b0; end
        else I_RD = 1'b0;
      end
      if (M_EN && order.size() > 0) begin
        p = order[0];
        wr_exp = (p == 1) && dwr;
        chk("m_addr", 64'(M_ADDR), p ? 64'(daddr) : 64'(iaddr));
        chk("m_be", 64'(M_BE), p ? 64'(be_norm(be)) : 64'(4'hF));
        chk("m_wr_rd", 64'({M_WR, M_RD}), 64'({wr_exp, ~wr_exp}));
        if (wr_exp) chk("m_wdata", 64'(M_WDATA), 64'(wd));
        if (acc_k == 0) begin
          if (force_d >= 0) cur_d = force_d;
          else if ($urandom_range(0, 4) == 0) cur_d = int'($urandom_range(13, 17));
          else cur_d = int'($urandom_range(0, 3));
        end
        M_ACK = (acc_k == cur_d);
        M_RDATA = M_WR ? $urandom : ram[M_ADDR[5:2]];
        if (M_ACK && M_WR) ram[M_ADDR[5:2]] = merge(ram[M_ADDR[5:2]], M_WDATA, M_BE);
        acc_k++;
      end else begin
        M_ACK = ($urandom_range(0, 1) == 1);
        M_RDATA = $urandom;
      end
    end
    chk("complete", 64'(order.size()), 64'(0));
    I_RD = 1'b0; D_RD = 1'b0; D_WR = 1'b0;
    @(posedge XCLK);
    @(negedge XCLK);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    I_RD = 0; I_ADDR = '0; D_RD = 0; D_WR = 0; D_BE = 0; D_ADDR = '0; D_WDATA = 0;
    M_RDATA = 0; M_ACK = 0;
    for (int i = 0; i < 16; i++) begin
      ram[i] = 32'h1000_0000 + 32'(i * 32'h0101);
      ref_mem[i] = ram[i];
    end
    ram[4] = 32'h12345678;
    ref_mem[4] = 32'h12345678;

    // Reset state
    XRES = 1'b0;
    repeat (2) @(negedge XCLK);
    chk("rst_strobes", 64'({M_EN, M_RD, M_WR, M_BE}), 64'(0));
    chk("rst_maddr", 64'(M_ADDR), 64'(0));
    chk("rst_mwdata", 64'(M_WDATA), 64'(0));
    chk("rst_acks_err", 64'({I_ACK, D_ACK, ERR}), 64'(0));
    chk("rst_rdata", 64'({I_DATA, D_RDATA}), 64'(0));
    XRES = 1'b1;
    exp_last = 0;

    // Fetch with zero-wait memory
    run_txn(1, 0, 0, 4'h0, 32'h10, 32'h0, 32'h0, 0);
    // Full-word data write
    run_txn(0, 1, 1, 4'h0, 32'h0, 32'h20, 32'hCAFEF00D, 0);
    // Simultaneous requests, repeated to see the grant order evolve
    for (int k = 0; k < 4; k++)
      run_txn(1, 1, 0, 4'h0, 32'h30 + 32'(k * 4), 32'h20, 32'h0, 0);
    // Byte-lane write with ACK after 3 wait cycles
    run_txn(0, 1, 1, 4'b0100, 32'h0, 32'h28, 32'hA5A5A5A5, 3);
    run_txn(0, 1, 0, 4'h0, 32'h0, 32'h28, 32'h0, 1);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(1, 3));
      run_txn(sel[0], sel[1], ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)),
              $urandom, $urandom, $urandom, -1);
    end

    // Timeout: memory never acknowledges
    run_txn(0, 1, 0, 4'h0, 32'h0, 32'h2C, 32'h0, 20);
    chk("err_hold", 64'(ERR), 64'(1));
    chk("rdata_hold", 64'(D_RDATA), 64'(0));

    // Asynchronous reset in the middle of an access
    M_ACK = 1'b0; I_RD = 1'b0; D_RD = 1'b1; D_WR = 1'b0; D_ADDR = 32'h14; D_BE = 4'h0;
    @(posedge XCLK);
    @(negedge XCLK);
    chk("pre_rst_men", 64'(M_EN), 64'(1));
    #2 XRES = 1'b0;
    #1;
    chk("async_rst_strobes", 64'({M_EN, M_RD, M_WR, M_BE}), 64'(0));
    chk("async_rst_acks", 64'({I_ACK, D_ACK}), 64'(0));
    chk("async_rst_err", 64'(ERR), 64'(0));
    @(negedge XCLK);
    XRES = 1'b1;
    exp_last = 0;
    run_txn(1, 1, 0, 4'h0, 32'h18, 32'h14, 32'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/darkmem_arb.md
Name: darkmem_arb

Overview:
Two-requester arbiter and sequencer in front of the single-port on-chip/external program-data RAM.
- Instruction fetch port (read-only) and data load/store port share one memory port.
- A small FSM serialises accesses, waits on memory ACK and bounds the wait with a timeout.
- Returns registered read data plus a one-cycle ACK to the winning requester.

Parameters:
WAIT_MAX, 15, max cycles in ACCESS waiting for M_ACK before timeout abort (1..255)
AW, 32, address width

Ports:
XCLK  in  1  system clock, all logic on rising edge
XRES  in  1  asynchronous active-low reset
I_RD  in  1  instruction fetch request, held until I_ACK
I_ADDR  in  AW  fetch byte address
I_DATA  out  32  fetched word, valid when I_ACK=1
I_ACK  out  1  one-cycle completion pulse, fetch port
D_RD  in  1  data read request, held until D_ACK
D_WR  in  1  data write request, held until D_ACK
D_BE  in  4  byte enables; 0 means full word
D_ADDR  in  AW  data byte address
D_WDATA  in  32  write data
D_RDATA  out  32  read word, valid when D_ACK=1
D_ACK  out  1  one-cycle completion pulse, data port
ERR  out  1  timeout flag, qualified by I_ACK or D_ACK
M_EN, M_RD, M_WR  out  1 each  memory strobes
M_BE  out  4  memory byte enables
M_ADDR  out  AW  memory address
M_WDATA  out  32  memory write data
M_RDATA  in  32  memory read data
M_ACK  in  1  memory completion; tie 1 for zero-wait RAM

Behaviour:
- Reset (XRES=0, any time, including mid-access): state=IDLE; last_grant=INSTR; counter=0; all outputs 0 (I_DATA, D_RDATA, M_* all 0; ERR=0).
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Data request = D_RD|D_WR.
  - If no request, stay in IDLE.
  - Otherwise latch grant (see priority), address, BE and wdata into registers; go to ACCESS. Counter=0.
- ACCESS:
  - M_EN=1; M_* driven from the latched registers only, never combinationally from requester inputs.
  - Data port with D_WR=1: M_WR=1, M_RD=0 (write wins if both set). Otherwise M_RD=1.
  - Fetch: M_RD=1, M_BE=4'hF.
  - D_BE=0 is presented as M_BE=4'hF.
  - If M_ACK=1: capture M_RDATA into the read register (writes capture 0); ERR=0; go to RESP.
  - Else if counter==WAIT_MAX-1: read register=0; ERR=1; go to RESP.
  - Else counter++.
- RESP:
  - Granted port's ACK=1 for exactly this cycle; M_EN=0.
  - Read data and ERR hold until the next RESP.
  - last_grant=granted port; go to IDLE.
- Latency: minimum 3 cycles from request assertion to the ACK cycle (IDLE, ACCESS with M_ACK=1, RESP). Timeout case: WAIT_MAX+2 cycles.
- Requester rule: request and attributes stay stable until ACK. A request still high in the cycle after ACK is treated as a new request.
- Priority (default build): fixed, data port wins on simultaneous requests.
- A losing request stays pending, with no ACK, and is served on the next IDLE pass.
- Never two ACKs in one cycle; never M_EN in IDLE or RESP.

Optional Feature:
Macro DARKMEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, grant the port not equal to last_grant; single requests are granted immediately.
- Undefined: fixed data-first priority; last_grant is kept but unused for arbitration.

Decomposition:
Package darkmem_arb_pkg:
- typedef enum state_t {IDLE, ACCESS, RESP}
- typedef enum grant_t {GNT_INSTR, GNT_DATA}
- localparam BE_FULL=4'hF
- function to normalise BE (0 -> BE_FULL)

Sub-module darkmem_arb_pick: combinational grant selection from (i_req, d_req, last_grant), isolating the macro-dependent logic. FSM, counter and datapath registers stay in darkmem_arb.

Test Plan:
- M_ACK tied 1, I_RD=1, I_ADDR=0x10, M_RDATA=0x12345678: M_EN high cycle 1; I_ACK high cycle 2; I_DATA=0x12345678, ERR=0.
- D_WR=1, D_BE=0, D_ADDR=0x20, D_WDATA=0xCAFEF00D: M_WR=1, M_BE=0xF, M_ADDR=0x20, M_WDATA=0xCAFEF00D for one cycle; D_ACK cycle 2; no I_ACK.
- I_RD and D_RD asserted same cycle, held:
  - Default build: D_ACK first (cycle 2), I_ACK at cycle 5.
  - With DARKMEM_ARB_ROUND_ROBIN_EN after reset (last_grant=INSTR): D_ACK first.
  - Repeated continuous dual requests alternate D, I, D, I.
- M_ACK held 0, WAIT_MAX=15, D_RD=1: M_EN high 15 cycles; D_ACK with ERR=1 and D_RDATA=0 at cycle 16; then back to IDLE.
- M_ACK delayed 3 cycles, D_WR=1, D_BE=4'b0100: M_BE=0x4 stable all 4 ACCESS cycles; D_ACK one cycle after M_ACK.
- XRES pulsed low mid-ACCESS: M_EN, ACKs and ERR drop to 0 asynchronously; after release with the request held, a fresh 3-cycle access completes correctly.
